// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding and wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous write, registered read.
// No reset; contents persist across core resets.
module dmem_array #(
  parameter  int n     = 16,
  parameter  int DEPTH = 64,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [n-1:0]  wdata,
  input  logic [IW-1:0] ridx,
  output logic [n-1:0]  rdata
);

  logic [n-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder with fixed wait states.
// Holds FSM, capture registers, wait counter and range check.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int n     = 16,
  parameter int DEPTH = 64,
  parameter int WAIT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] rdata,
  output logic         ready,
  output logic         err,
  output logic         busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);
  localparam logic [n-2:0] DEPTH_W = (n-1)'(DEPTH);

  dmem_state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic cap_we;
  logic [n-1:0] cap_addr, cap_wdata;
  logic src_we;
  logic [n-1:0] src_addr, src_wdata;
  logic src_bad, cap_bad, commit;
  logic [n-1:0] arr_rdata;

  function automatic logic bad_addr(input logic [n-1:0] a);
    return a[0] | (a[n-1:1] >= DEPTH_W);
  endfunction

  // In IDLE the live inputs feed the array so WAIT=0 can commit
  // on the capture edge itself.
  assign src_we    = (state == IDLE) ? we    : cap_we;
  assign src_addr  = (state == IDLE) ? addr  : cap_addr;
  assign src_wdata = (state == IDLE) ? wdata : cap_wdata;
  assign src_bad   = bad_addr(src_addr);
  assign cap_bad   = bad_addr(cap_addr);
  assign busy      = (state != IDLE);
  assign commit    = (next == RESP) && (state != RESP)
                   && src_we && !src_bad;

  dmem_array #(
    .n     (n),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (commit),
    .widx  (src_addr[IW:1]),
    .wdata (src_wdata),
    .ridx  (src_addr[IW:1]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (req) next = (WAIT == 0) ? RESP : dmem_pkg::WAIT;
      dmem_pkg::WAIT: if (cnt == CNT_W'(1)) next = RESP;
      RESP: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cnt       <= WAIT_CNT;
          end
        end
        dmem_pkg::WAIT: cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Response flags register out of RESP, one cycle after the array read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= (state == RESP);
      err   <= (state == RESP) && cap_bad;
      rdata <= (state == RESP && !cap_we && !cap_bad)
               ? arr_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder, four WAIT settings.
// Model: plain word array plus per-request expected responses.
module tb_dmem_responder;

  localparam int NI = 4;

  typedef struct {
    int          due;
    logic        bad;
    logic [15:0] data;
    bit          known;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic [15:0] addr  [NI];
  logic [15:0] wdata [NI];
  logic [15:0] rdata [NI];
  logic        ready [NI];
  logic        err   [NI];
  logic        busy  [NI];

  exp_t        sb [NI][$];
  logic [15:0] mdl [NI][64];
  bit          known [NI][64];
  int          busy_lo [NI];
  int          busy_hi [NI];
  int          checks = 0;
  int          failures = 0;

  function automatic int wt(int i);
    case (i)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  dmem_responder #(.n(16), .DEPTH(64), .WAIT(1)) u_w1 (
    .clk(clk), .reset(rst_n[0]), .req(req[0]), .we(we[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .ready(ready[0]), .err(err[0]), .busy(busy[0]));

  dmem_responder #(.n(16), .DEPTH(64), .WAIT(0)) u_w0 (
    .clk(clk), .reset(rst_n[1]), .req(req[1]), .we(we[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .ready(ready[1]), .err(err[1]), .busy(busy[1]));

  dmem_responder #(.n(16), .DEPTH(64), .WAIT(3)) u_w3 (
    .clk(clk), .reset(rst_n[2]), .req(req[2]), .we(we[2]),
    .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]),
    .ready(ready[2]), .err(err[2]), .busy(busy[2]));

  dmem_responder #(.n(16), .DEPTH(64), .WAIT(15)) u_w15 (
    .clk(clk), .reset(rst_n[3]), .req(req[3]), .we(we[3]),
    .addr(addr[3]), .wdata(wdata[3]), .rdata(rdata[3]),
    .ready(ready[3]), .err(err[3]), .busy(busy[3]));

  task automatic check(string nm, int i,
                       logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h t=%0t",
               nm, i, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per ready strobe.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst_n[i] === 1'b1) begin
        check("busy", i, 32'(busy[i]),
              32'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));
        if (ready[i] === 1'b1) begin
          if (sb[i].size() == 0) begin
            check("spurious_ready", i, 32'(ready[i]), 32'(0));
          end else begin
            e = sb[i].pop_front();
            check("ready_cycle", i, 32'(cyc), 32'(e.due));
            check("err", i, 32'(err[i]), 32'(e.bad));
            if (e.known)
              check("rdata", i, 32'(rdata[i]), 32'(e.data));
          end
        end else begin
          check("quiet_outputs", i, 32'({err[i], rdata[i]}), 32'(0));
        end
      end
    end
  end

  task automatic idle(int i, int cycles);
    req[i] = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Issue one request to an idle DUT, then scramble inputs until ready.
  task automatic xact(int i, bit w, logic [15:0] a, logic [15:0] d);
    exp_t e;
    int word;
    int cap;
    bit got;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk); #1;
    cap = cyc;
    word = int'(a[15:1]);
    e.due = cap + wt(i) + 1;
    e.bad = a[0] || word >= 64;
    e.data = 16'h0;
    e.known = 1'b1;
    if (!e.bad) begin
      if (w) begin
        mdl[i][word] = d;
        known[i][word] = 1'b1;
      end else begin
        e.data = mdl[i][word];
        e.known = known[i][word];
      end
    end
    sb[i].push_back(e);
    busy_lo[i] = cap;
    busy_hi[i] = cap + wt(i);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ready[i] === 1'b1) got = 1'b1;
      else begin
        req[i] = 1'($urandom);
        we[i] = 1'($urandom);
        addr[i] = 16'($urandom);
        wdata[i] = 16'($urandom);
      end
    end
    if (!got) check("ready_timeout", i, 32'(ready[i]), 32'(1));
  endtask

  task automatic rand_run(int i, int cnt);
    logic [15:0] a;
    int r;
    for (int k = 0; k < cnt; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 16'($urandom_range(0, 15) * 2);
      else if (r == 7) a = 16'($urandom_range(0, 63) * 2 + 1);
      else if (r == 8) a = 16'($urandom_range(64, 32767) * 2);
      else             a = 16'($urandom_range(0, 63) * 2);
      xact(i, 1'($urandom), a, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle(i, int'($urandom_range(1, 3)));
    end
    idle(i, 1);
  endtask

  task automatic run0();
    xact(0, 1'b1, 16'h0004, 16'hBEEF);
    idle(0, 1);
    xact(0, 1'b0, 16'h0004, 16'h0000);
    xact(0, 1'b1, 16'h0006, 16'h1111);
    xact(0, 1'b0, 16'h0004, 16'h0000);
    xact(0, 1'b1, 16'h0002, 16'h5A5A);
    xact(0, 1'b0, 16'h0003, 16'h0000);
    xact(0, 1'b1, 16'h0081, 16'hDEAD);
    xact(0, 1'b1, 16'h0080, 16'hDEAD);
    xact(0, 1'b0, 16'h0002, 16'h0000);
    idle(0, 2);
    rand_run(0, 40);
  endtask

  task automatic run1();
    for (int k = 0; k < 4; k++)
      xact(1, 1'b1, 16'(k * 2), 16'($urandom));
    for (int k = 0; k < 4; k++)
      xact(1, 1'b0, 16'(k * 2), 16'h0000);
    idle(1, 2);
    rand_run(1, 40);
  endtask

  task automatic run2();
    xact(2, 1'b1, 16'h0010, 16'hAAAA);
    idle(2, 2);
    req[2] = 1'b1; we[2] = 1'b1;
    addr[2] = 16'h0010; wdata[2] = 16'h1234;
    @(posedge clk); #1;
    busy_lo[2] = cyc;
    busy_hi[2] = cyc + 3;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk); #2;
    rst_n[2] = 1'b0;
    busy_lo[2] = 1;
    busy_hi[2] = 0;
    #1;
    check("abort_outputs", 2,
          32'({ready[2], err[2], busy[2], rdata[2]}), 32'(0));
    @(negedge clk); #2;
    rst_n[2] = 1'b1;
    idle(2, 6);
    xact(2, 1'b0, 16'h0010, 16'h0000);
    idle(2, 1);
    rand_run(2, 25);
  endtask

  task automatic run3();
    xact(3, 1'b1, 16'h0020, 16'hC0DE);
    xact(3, 1'b0, 16'h0020, 16'h0000);
    idle(3, 1);
    rand_run(3, 8);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0;
      busy_lo[i] = 1; busy_hi[i] = 0;
    end
    #12;
    for (int i = 0; i < NI; i++)
      check("reset_outputs", i,
            32'({ready[i], err[i], busy[i], rdata[i]}), 32'(0));
    @(negedge clk);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    fork
      run0();
      run1();
      run2();
      run3();
    join
    repeat (20) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check("drain", i, 32'(sb[i].size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
